dsp_io_bridge: RTL and testbench

- Parametrised successor to the DSP I/O addressing logic.
- Frame-synchronous, double-buffered bridge between the codec sample ports and the DSP core's I/O bus, for N channels.
- Inputs are snapshotted and outputs published together on each frame tick, so the DSP sees a coherent frame.
- Converts between IO_WIDTH codec samples and SAMPLE_WIDTH DSP words, and reports DSP frame overruns.

---
 rtl/dsp_io_pkg.sv | 57 +++++
 rtl/dsp_io_frame_ctl.sv | 52 +++++
 rtl/dsp_io_bridge.sv | 113 +++++++++++
 tb/tb_dsp_io_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_io_pkg.sv
// Shared types, default widths and the DSP-word to codec-sample narrowing helpers.
// DSP_IO_SATURATE_EN selects clamping instead of MSB truncation in sat_narrow.
package dsp_io_pkg;

  localparam int DEF_NUM_CH        = 8;
  localparam int DEF_IO_WIDTH      = 24;
  localparam int DEF_SAMPLE_WIDTH  = 36;
  localparam int DEF_ALIGN_SHIFT   = 8;
  localparam int DEF_ADDR_WIDTH    = 6;
  localparam int DEF_OVR_CNT_WIDTH = 16;

  // Working width for the conversion; callers sign-extend into it and cast the result down.
  localparam int NARROW_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } io_fsm_t;

  function automatic logic [NARROW_W-1:0] sat_narrow(
    input logic signed [NARROW_W-1:0] wide,
    input int                         shift,
    input int                         io_width
  );
    logic signed [NARROW_W-1:0] shifted;
`ifdef DSP_IO_SATURATE_EN
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
`endif
    shifted = wide >>> shift;
`ifdef DSP_IO_SATURATE_EN
    hi = (NARROW_W'(1) <<< (io_width - 1)) - NARROW_W'(1);
    lo = -hi - NARROW_W'(1);
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
`endif
    return shifted & ~({NARROW_W{1'b1}} << io_width);
  endfunction

`ifdef DSP_IO_SATURATE_EN
  function automatic logic sat_clipped(
    input logic signed [NARROW_W-1:0] wide,
    input int                         shift,
    input int                         io_width
  );
    logic signed [NARROW_W-1:0] shifted;
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    shifted = wide >>> shift;
    hi = (NARROW_W'(1) <<< (io_width - 1)) - NARROW_W'(1);
    lo = -hi - NARROW_W'(1);
    return (shifted > hi) || (shifted < lo);
  endfunction
`endif

endpackage

// File: rtl/dsp_io_frame_ctl.sv
// Frame sequencing FSM: tracks whether the DSP finished its frame, raises
// frame_start on every tick and flags/counts ticks that land while still busy.
module dsp_io_frame_ctl
  import dsp_io_pkg::*;
#(
  parameter int OVR_CNT_WIDTH = DEF_OVR_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     dsp_done,
  output logic                     frame_start,
  output logic                     overrun,
  output logic [OVR_CNT_WIDTH-1:0] overrun_count
);

  io_fsm_t                  state_reg;
  logic                     frame_start_reg;
  logic                     overrun_reg;
  logic [OVR_CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      frame_start_reg <= 1'b0;
      overrun_reg     <= 1'b0;
      count_reg       <= '0;
    end else begin
      // Every tick lands in RUN from any state, so frame_start simply follows it.
      frame_start_reg <= frame_tick;
      overrun_reg     <= 1'b0;
      case (state_reg)
        IDLE: if (frame_tick) state_reg <= RUN;
        RUN: begin
          if (frame_tick) begin
            overrun_reg <= 1'b1;
            if (count_reg != '1) count_reg <= count_reg + 1'b1;
          end else if (dsp_done) begin
            state_reg <= WAIT;
          end
        end
        WAIT: if (frame_tick) state_reg <= RUN;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign frame_start   = frame_start_reg;
  assign overrun       = overrun_reg;
  assign overrun_count = count_reg;

endmodule

// File: rtl/dsp_io_bridge.sv
// Frame-synchronous double-buffered bridge between codec sample ports and the DSP I/O bus.
// Build option DSP_IO_SATURATE_EN: clamp DSP writes to the codec range and report clip.
module dsp_io_bridge
  import dsp_io_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int IO_WIDTH      = DEF_IO_WIDTH,
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int ALIGN_SHIFT   = DEF_ALIGN_SHIFT,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int OVR_CNT_WIDTH = DEF_OVR_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [NUM_CH*IO_WIDTH-1:0] audio_inputs,
  output logic [NUM_CH*IO_WIDTH-1:0] audio_outputs,
  input  logic                       io_rd_en,
  input  logic [ADDR_WIDTH-1:0]      io_rd_addr,
  output logic [SAMPLE_WIDTH-1:0]    io_rd_data,
  input  logic                       io_wr_en,
  input  logic [ADDR_WIDTH-1:0]      io_wr_addr,
  input  logic [SAMPLE_WIDTH-1:0]    io_wr_data,
  input  logic                       dsp_done,
  output logic                       frame_start,
  output logic                       overrun,
  output logic [OVR_CNT_WIDTH-1:0]   overrun_count,
  output logic                       clip
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*IO_WIDTH-1:0]  snap_bus;
  logic [IDX_W-1:0]            rd_idx;
  logic                        rd_in_range;
  logic signed [IO_WIDTH-1:0]  rd_sample;
  logic [SAMPLE_WIDTH-1:0]     rd_data_reg;
  logic [SAMPLE_WIDTH-1:0]     rd_data_next;
  logic signed [NARROW_W-1:0]  wr_wide;
  logic [IO_WIDTH-1:0]         wr_narrow;

  assign wr_wide   = NARROW_W'($signed(io_wr_data));
  assign wr_narrow = IO_WIDTH'(sat_narrow(wr_wide, ALIGN_SHIFT, IO_WIDTH));

  // Out-of-range write addresses match no channel and are dropped here.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [IO_WIDTH-1:0] snap_reg;
    logic [IO_WIDTH-1:0] stage_reg;
    logic [IO_WIDTH-1:0] out_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        snap_reg  <= '0;
        stage_reg <= '0;
        out_reg   <= '0;
      end else begin
        if (frame_tick) begin
          snap_reg <= audio_inputs[gi*IO_WIDTH +: IO_WIDTH];
          out_reg  <= stage_reg;
        end
        if (io_wr_en && (io_wr_addr == ADDR_WIDTH'(gi))) stage_reg <= wr_narrow;
      end
    end

    assign snap_bus[gi*IO_WIDTH +: IO_WIDTH]      = snap_reg;
    assign audio_outputs[gi*IO_WIDTH +: IO_WIDTH] = out_reg;
  end

  assign rd_idx      = io_rd_addr[IDX_W-1:0];
  assign rd_in_range = 32'(io_rd_addr) < NUM_CH;
  assign rd_sample   = snap_bus[rd_idx*IO_WIDTH +: IO_WIDTH];

  always_comb begin
    rd_data_next = '0;
    if (rd_in_range) rd_data_next = SAMPLE_WIDTH'(rd_sample) << ALIGN_SHIFT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_reg <= '0;
    else if (io_rd_en) rd_data_reg <= rd_data_next;
  end

  assign io_rd_data = rd_data_reg;

`ifdef DSP_IO_SATURATE_EN
  logic clip_reg;
  logic wr_in_range;

  assign wr_in_range = 32'(io_wr_addr) < NUM_CH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clip_reg <= 1'b0;
    else if (io_wr_en && wr_in_range && sat_clipped(wr_wide, ALIGN_SHIFT, IO_WIDTH)) clip_reg <= 1'b1;
  end

  assign clip = clip_reg;
`else
  assign clip = 1'b0;
`endif

  dsp_io_frame_ctl #(
    .OVR_CNT_WIDTH(OVR_CNT_WIDTH)
  ) u_frame_ctl (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .dsp_done     (dsp_done),
    .frame_start  (frame_start),
    .overrun      (overrun),
    .overrun_count(overrun_count)
  );

endmodule

// File: tb/tb_dsp_io_bridge.sv
// Scoreboard bench for dsp_io_bridge: stimulus queues expected read/tick results,
// a negedge monitor pops and compares them when the DUT presents the response.
module tb_dsp_io_bridge;

  localparam int NUM_CH = 8;
  localparam int IO_W   = 24;
  localparam int S_W    = 36;
  localparam int AW     = 6;
  localparam int CW     = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   frame_tick = 1'b0;
  logic [NUM_CH*IO_W-1:0] audio_inputs = '0;
  logic [NUM_CH*IO_W-1:0] audio_outputs;
  logic                   io_rd_en = 1'b0;
  logic [AW-1:0]          io_rd_addr = '0;
  logic [S_W-1:0]         io_rd_data;
  logic                   io_wr_en = 1'b0;
  logic [AW-1:0]          io_wr_addr = '0;
  logic [S_W-1:0]         io_wr_data = '0;
  logic                   dsp_done = 1'b0;
  logic                   frame_start;
  logic                   overrun;
  logic [CW-1:0]          overrun_count;
  logic                   clip;

  dsp_io_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .audio_inputs (audio_inputs),
    .audio_outputs(audio_outputs),
    .io_rd_en     (io_rd_en),
    .io_rd_addr   (io_rd_addr),
    .io_rd_data   (io_rd_data),
    .io_wr_en     (io_wr_en),
    .io_wr_addr   (io_wr_addr),
    .io_wr_data   (io_wr_data),
    .dsp_done     (dsp_done),
    .frame_start  (frame_start),
    .overrun      (overrun),
    .overrun_count(overrun_count),
    .clip         (clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [23:0] val;
    bit          fs;
    bit          ovr;
    logic [15:0] cnt;
  } tick_exp_t;

  tick_exp_t   tick_q[$];
  logic [35:0] rd_q[$];
  tick_exp_t   te;
  logic [35:0] re;
  int          n_vec = 0;
  int          n_err = 0;
  logic        rd_fire;
  logic        tick_fire;

`ifdef DSP_IO_SATURATE_EN
  localparam logic [23:0] CH0_EXP  = 24'h7FFFFF;
  localparam logic        CLIP_EXP = 1'b1;
`else
  localparam logic [23:0] CH0_EXP  = 24'hFFFFFF;
  localparam logic        CLIP_EXP = 1'b0;
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // The DUT has no valid strobe; a read or tick one edge earlier marks a response.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_fire   <= 1'b0;
      tick_fire <= 1'b0;
    end else begin
      rd_fire   <= io_rd_en;
      tick_fire <= frame_tick;
    end
  end

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h want no read", io_rd_data);
      end else begin
        re = rd_q.pop_front();
        check("rd_data", 256'(io_rd_data), 256'(re));
      end
    end
    if (tick_fire) begin
      if (tick_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tick_unexpected: got tick want none");
      end else begin
        te = tick_q.pop_front();
        check($sformatf("tick_out_ch%0d", te.ch), 256'(audio_outputs[te.ch*IO_W +: IO_W]), 256'(te.val));
        check("tick_frame_start", 256'(frame_start), 256'(te.fs));
        check("tick_overrun", 256'(overrun), 256'(te.ovr));
        check("tick_overrun_count", 256'(overrun_count), 256'(te.cnt));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int ch, input logic [23:0] val, input bit fs, input bit ovr, input logic [15:0] cnt);
    tick_exp_t e;
    e.ch = ch; e.val = val; e.fs = fs; e.ovr = ovr; e.cnt = cnt;
    tick_q.push_back(e);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [35:0] exp);
    rd_q.push_back(exp);
    io_rd_en = 1'b1;
    io_rd_addr = addr;
    cyc();
    io_rd_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [35:0] data);
    io_wr_en = 1'b1;
    io_wr_addr = addr;
    io_wr_data = data;
    cyc();
    io_wr_en = 1'b0;
  endtask

  task automatic done();
    dsp_done = 1'b1;
    cyc();
    dsp_done = 1'b0;
  endtask

  logic [NUM_CH*IO_W-1:0] exp_vec;

  initial begin
    repeat (3) cyc();
    check("reset_audio_outputs", 256'(audio_outputs), 256'(0));
    check("reset_rd_data", 256'(io_rd_data), 256'(0));
    check("reset_flags", 256'({frame_start, overrun, clip}), 256'(0));
    check("reset_overrun_count", 256'(overrun_count), 256'(0));
    reset = 1'b0;
    cyc();

    // Most negative codec sample sign-extends and aligns.
    audio_inputs[3*IO_W +: IO_W] = 24'h800000;
    audio_inputs[1*IO_W +: IO_W] = 24'h000001;
    tick(0, 24'h000000, 1'b1, 1'b0, 16'd0);
    rd(3, 36'hF80000000);
    rd(1, 36'h000000100);
    done();

    // Writes sit in staging until the next tick.
    wr(5, 36'h000012345);
    check("ch5_before_tick", 256'(audio_outputs[5*IO_W +: IO_W]), 256'(0));
    wr(0, 36'h7FFFFFFFF);
    tick(5, 24'h000123, 1'b1, 1'b0, 16'd0);
    check("ch0_overflow_write", 256'(audio_outputs[0*IO_W +: IO_W]), 256'(CH0_EXP));
    check("clip_flag", 256'(clip), 256'(CLIP_EXP));

    // Tick without dsp_done is an overrun; with dsp_done it is not.
    tick(5, 24'h000123, 1'b1, 1'b1, 16'd1);
    done();
    tick(5, 24'h000123, 1'b1, 1'b0, 16'd1);

    // Write and read in the tick cycle: write lands next frame, read sees old snapshot.
    io_wr_en = 1'b1; io_wr_addr = 2; io_wr_data = 36'h000ABCD00;
    io_rd_en = 1'b1; io_rd_addr = 3; rd_q.push_back(36'hF80000000);
    audio_inputs[3*IO_W +: IO_W] = 24'h000010;
    tick(2, 24'h000000, 1'b1, 1'b1, 16'd2);
    io_wr_en = 1'b0;
    io_rd_en = 1'b0;
    rd(3, 36'h000001000);
    done();
    tick(2, 24'h00ABCD, 1'b1, 1'b0, 16'd2);

    // Out-of-range addresses: read returns 0, write is dropped.
    rd(6'd8, 36'h000000000);
    wr(6'd8, 36'hFFFFFFFFF);
    done();
    tick(5, 24'h000123, 1'b1, 1'b0, 16'd2);
    exp_vec = '0;
    exp_vec[0*IO_W +: IO_W] = CH0_EXP;
    exp_vec[2*IO_W +: IO_W] = 24'h00ABCD;
    exp_vec[5*IO_W +: IO_W] = 24'h000123;
    check("all_outputs_after_oor_write", 256'(audio_outputs), 256'(exp_vec));

    // Asynchronous reset mid-RUN clears everything before the next edge.
    rd(1, 36'h000000100);
    cyc();
    reset = 1'b1;
    #1;
    check("async_rst_audio_outputs", 256'(audio_outputs), 256'(0));
    check("async_rst_rd_data", 256'(io_rd_data), 256'(0));
    check("async_rst_overrun_count", 256'(overrun_count), 256'(0));
    check("async_rst_clip", 256'(clip), 256'(0));
    cyc();
    reset = 1'b0;
    cyc();
    tick(5, 24'h000000, 1'b1, 1'b0, 16'd0);

    repeat (3) cyc();
    check("scoreboard_drained", 256'(rd_q.size() + tick_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
